// File: rtl/bl_wl_config_driver_if.sv
// Configuration stream and tile-facing bit-line/word-line bundle for bl_wl_config_driver.
// The driver connects through the slave modport; the bitstream source uses master.
interface bl_wl_config_driver_if #(
    parameter int BL_WIDTH   = 40,
    parameter int WL_WIDTH   = 4,
    parameter int WORD_WIDTH = 8
) ();
    logic                  cfg_start;
    logic [WORD_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_last;
    logic                  cfg_ready;
    logic [BL_WIDTH-1:0]   bl_out;
    logic [WL_WIDTH-1:0]   wl_out;
    logic                  busy;
    logic                  cfg_done;
    logic                  cfg_error;

    modport master (
        output cfg_start, cfg_data, cfg_valid, cfg_last,
        input  cfg_ready, bl_out, wl_out, busy, cfg_done, cfg_error
    );

    modport slave (
        input  cfg_start, cfg_data, cfg_valid, cfg_last,
        output cfg_ready, bl_out, wl_out, busy, cfg_done, cfg_error
    );
endinterface

// File: rtl/bl_wl_config_driver.sv
// Memory-bank configuration driver: assembles one bit-line row per word line from the
// bitstream, then strobes that word line with setup/hold margins around the pulse.
//
// state | meaning
// IDLE  | after reset, waiting for cfg_start
// LOAD  | accepting words of the current row into bl_out
// SETUP | one cycle of bit-line settle before the strobe
// PULSE | word line of the current row high for WL_PULSE_CYCLES
// HOLD  | one cycle with word line low before bit lines may change
// DONE  | pass complete (cfg_done), cfg_error valid, waiting for cfg_start
module bl_wl_config_driver #(
    parameter int BL_WIDTH        = 40,
    parameter int WL_WIDTH        = 4,
    parameter int WORD_WIDTH      = 8,
    parameter int WL_PULSE_CYCLES = 2
) (
    input logic                  prog_clk,
    input logic                  prog_reset,
    bl_wl_config_driver_if.slave cfg
);
    localparam int WPR    = BL_WIDTH / WORD_WIDTH;
    localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int WORD_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int PCNT_W = $clog2(WL_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                err_q, err_d;

    logic                last_word;
    logic                last_row;
    logic [WL_WIDTH-1:0] wl_onehot;

    assign last_word = (word_q == WORD_W'(WPR - 1));
    assign last_row  = (row_q == ROW_W'(WL_WIDTH - 1));
    assign wl_onehot = WL_WIDTH'(1) << row_q;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            word_q  <= '0;
            pcnt_q  <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            pcnt_q  <= pcnt_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        pcnt_d  = pcnt_q;
        bl_d    = bl_q;
        err_d   = err_q;
        wl_d    = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg.cfg_start) begin
                    err_d   = 1'b0;
                    row_d   = '0;
                    word_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cfg.cfg_valid) begin
                    bl_d[int'(word_q)*WORD_WIDTH +: WORD_WIDTH] = cfg.cfg_data;
                    // An early cfg_last aborts the pass; the partial row is never strobed.
                    if (cfg.cfg_last && !(last_word && last_row)) begin
                        err_d   = 1'b1;
                        word_d  = '0;
                        state_d = S_DONE;
                    end else if (last_word) begin
                        word_d  = '0;
                        state_d = S_SETUP;
                        if (last_row && !cfg.cfg_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            S_SETUP: begin
                pcnt_d  = PCNT_W'(WL_PULSE_CYCLES - 1);
                wl_d    = wl_onehot;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (pcnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    pcnt_d = pcnt_q - PCNT_W'(1);
                    wl_d   = wl_onehot;
                end
            end
            S_HOLD: begin
                if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cfg.cfg_ready = (state_q == S_LOAD);
    assign cfg.busy      = (state_q == S_LOAD) || (state_q == S_SETUP) ||
                           (state_q == S_PULSE) || (state_q == S_HOLD);
    assign cfg.cfg_done  = (state_q == S_DONE);
    assign cfg.cfg_error = err_q;
    assign cfg.bl_out    = bl_q;
    assign cfg.wl_out    = wl_q;
endmodule

// File: tb/tb_bl_wl_config_driver.sv
// Bench for bl_wl_config_driver: table of programming passes, random passes, and
// hand-written reset/restart sequences, all checked against a row-level reference model.
module tb_bl_wl_config_driver;
    localparam int BLW = 40;
    localparam int WLW = 4;
    localparam int WW  = 8;
    localparam int P   = 2;
    localparam int N   = BLW / WW;
    localparam int TOT = WLW * N;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b1;

    bl_wl_config_driver_if #(.BL_WIDTH(BLW), .WL_WIDTH(WLW), .WORD_WIDTH(WW)) bus ();

    bl_wl_config_driver #(
        .BL_WIDTH(BLW), .WL_WIDTH(WLW), .WORD_WIDTH(WW), .WL_PULSE_CYCLES(P)
    ) dut (
        .prog_clk  (prog_clk),
        .prog_reset(prog_reset),
        .cfg       (bus)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mode;
        int nwords;
        int last_idx;
        int glitch_idx;
        bit rand_data;
        bit exp_err;
        int exp_rows;
    } vec_t;
    vec_t vecs[6];

    logic [WW-1:0]  words[TOT];
    logic [BLW-1:0] exp_bl[WLW];
    int             exp_row[WLW];
    int             nexp;
    bit             exp_err, exp_early;

    logic [BLW-1:0] got_bl[8];
    int             got_row[8];
    int             got_len[8];
    int             ngot;

    int cur_mode, cur_nwords, cur_last, cur_glitch;
    int idx, done_cyc, first_acc, acc_cyc, pend;
    bit glitched, aborted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int wl_index(input logic [WLW-1:0] w);
        for (int i = 0; i < WLW; i++) if (w[i]) return i;
        return -1;
    endfunction

    // Row-level expectation: which rows get strobed with which bit-line image, and the error flag.
    task automatic build_model(input int nwords, input int last_idx);
        logic [BLW-1:0] bl;
        bl = '0;
        nexp = 0; exp_err = 0; exp_early = 0;
        for (int i = 0; i < nwords; i++) begin
            bl[(i % N)*WW +: WW] = words[i];
            if (i == last_idx && i != TOT-1) begin
                exp_err = 1; exp_early = 1;
                break;
            end
            if (i % N == N-1) begin
                exp_row[nexp] = i / N;
                exp_bl[nexp]  = bl;
                nexp++;
                if (i == TOT-1 && last_idx != i) exp_err = 1;
            end
        end
    endtask

    task automatic drive(input int cyc);
        bit v;
        case (cur_mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
        endcase
        v = v && (idx < cur_nwords);
        bus.cfg_valid = v;
        bus.cfg_data  = (idx < cur_nwords) ? words[idx] : '0;
        bus.cfg_last  = v && (idx == cur_last);
        bus.cfg_start = 1'b0;
        if (!glitched && idx == cur_glitch) begin
            bus.cfg_start = 1'b1;
            glitched = 1;
        end
    endtask

    task automatic set_idle();
        bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_last = 0; bus.cfg_data = '0;
    endtask

    task automatic run_pass(input int mode, input int nwords, input int last_idx,
                            input int glitch_idx, input int abort_row);
        bit in_pulse, done_seen;
        logic [WLW-1:0] cur_wl;
        logic [BLW-1:0] cur_bl;
        int len;
        cur_mode = mode; cur_nwords = nwords; cur_last = last_idx; cur_glitch = glitch_idx;
        build_model(nwords, last_idx);
        ngot = 0; in_pulse = 0; done_seen = 0; idx = 0; glitched = 0; aborted = 0;
        first_acc = -1; acc_cyc = 0; pend = 0; done_cyc = 0; len = 0;
        cur_wl = '0; cur_bl = '0;
        // Start strobe with a word offered: it must not be taken while not in LOAD.
        @(posedge prog_clk); #1;
        bus.cfg_start = 1; bus.cfg_valid = 1; bus.cfg_data = 8'hAA; bus.cfg_last = 1;
        @(posedge prog_clk); #1;
        drive(0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge prog_clk);
            if (cyc == 0) begin
                chk("start_done_clear", bus.cfg_done, 0);
                chk("start_error_clear", bus.cfg_error, 0);
                chk("start_busy", bus.busy, 1);
                chk("start_ready", bus.cfg_ready, 1);
            end
            if (bus.wl_out != '0) begin
                chk("wl_onehot", $onehot(bus.wl_out), 1);
                chk("ready_low_in_pulse", bus.cfg_ready, 0);
                chk("busy_in_pulse", bus.busy, 1);
                if (abort_row >= 0 && bus.wl_out[abort_row]) begin
                    aborted = 1;
                    return;
                end
                if (!in_pulse) begin
                    in_pulse = 1; cur_wl = bus.wl_out; cur_bl = bus.bl_out; len = 1;
                    chk("accept_to_pulse", cyc - acc_cyc, 2);
                end else begin
                    chk("wl_stable", bus.wl_out, cur_wl);
                    chk("bl_stable", bus.bl_out, cur_bl);
                    len++;
                end
            end else if (in_pulse) begin
                in_pulse = 0;
                if (ngot < 8) begin
                    got_row[ngot] = wl_index(cur_wl);
                    got_bl[ngot]  = cur_bl;
                    got_len[ngot] = len;
                end
                ngot++;
                pend = cyc - 1;
            end
            if (bus.cfg_done) begin
                done_seen = 1; done_cyc = cyc;
                break;
            end
            if (bus.cfg_valid && bus.cfg_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_cyc = cyc;
                idx++;
            end
            @(posedge prog_clk); #1;
            drive(cyc + 1);
        end
        set_idle();
        chk("done_reached", done_seen, 1);
        chk("cfg_error", bus.cfg_error, exp_err);
        chk("busy_at_done", bus.busy, 0);
        chk("ready_at_done", bus.cfg_ready, 0);
        chk("rows_pulsed", ngot, nexp);
        for (int i = 0; i < nexp && i < ngot && i < 8; i++) begin
            chk("pulse_row", got_row[i], exp_row[i]);
            chk("pulse_bl", got_bl[i], exp_bl[i]);
            chk("pulse_len", got_len[i], P);
        end
        if (exp_early) chk("early_done_latency", done_cyc - acc_cyc, 1);
        else           chk("hold_to_done", done_cyc - pend, 2);
        if (mode == 0 && !exp_early && glitch_idx < 0)
            chk("pass_cycles", done_cyc - first_acc, WLW*(N+2+P));
    endtask

    initial begin
        set_idle();
        #12;
        chk("rst_bl", bus.bl_out, 0);
        chk("rst_wl", bus.wl_out, 0);
        chk("rst_ready", bus.cfg_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.cfg_done, 0);
        chk("rst_error", bus.cfg_error, 0);
        @(negedge prog_clk);
        prog_reset = 0;

        // mode, nwords, last_idx, glitch_idx, rand_data, exp_err, exp_rows
        vecs[0] = '{0, 20, 19, -1, 0, 0, 4};
        vecs[1] = '{1, 20, 19, -1, 0, 0, 4};
        vecs[2] = '{0,  8,  7, -1, 0, 1, 1};
        vecs[3] = '{0, 20, -1, -1, 0, 1, 4};
        vecs[4] = '{0, 20, 19,  3, 0, 0, 4};
        vecs[5] = '{2, 20, 19, -1, 1, 0, 4};

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < TOT; i++) words[i] = vecs[v].rand_data ? WW'($urandom) : WW'(i);
            run_pass(vecs[v].mode, vecs[v].nwords, vecs[v].last_idx, vecs[v].glitch_idx, -1);
            chk("tbl_error", bus.cfg_error, vecs[v].exp_err);
            chk("tbl_done", bus.cfg_done, 1);
            chk("tbl_rows", ngot, vecs[v].exp_rows);
            if (v == 0) begin
                chk("row0_bl", got_bl[0], 40'h0403020100);
                chk("row0_wl", got_row[0], 0);
                chk("row3_bl", got_bl[3], 40'h131211100F);
                chk("row3_wl", got_row[3], 3);
            end
            if (v == 2) begin
                for (int i = 0; i < ngot && i < 8; i++) chk("row1_never_pulsed", got_row[i] == 1, 0);
            end
        end

        // Reset landing in the middle of the row 2 strobe.
        for (int i = 0; i < TOT; i++) words[i] = WW'(i);
        run_pass(0, 20, 19, -1, 2);
        chk("abort_reached", aborted, 1);
        set_idle();
        #2 prog_reset = 1;
        #1;
        chk("midrst_wl", bus.wl_out, 0);
        chk("midrst_bl", bus.bl_out, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.cfg_ready, 0);
        chk("midrst_done", bus.cfg_done, 0);
        chk("midrst_error", bus.cfg_error, 0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        prog_reset = 0;
        run_pass(0, 20, 19, -1, -1);
        chk("post_rst_row0_bl", got_bl[0], 40'h0403020100);
        chk("post_rst_error", bus.cfg_error, 0);

        // Random data, random gaps, random framing.
        for (int r = 0; r < 8; r++) begin
            int l;
            for (int i = 0; i < TOT; i++) words[i] = WW'($urandom);
            l = $urandom_range(0, 20);
            if (l == 20) run_pass(2, 20, -1, -1, -1);
            else         run_pass(2, l + 1, l, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
